// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic units.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Bit counter width for a WIDTH-bit serial operation (at least one bit).
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit combinational full adder; the only arithmetic cell of the serial datapath.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b (as a + ~b + 1), LSB first, with valid/ready on operands and result.
//   state | meaning
//   IDLE  | waiting for operands, start_ready high
//   RUN   | one result bit per cycle through the full-adder cell
//   DONE  | result and flags held, res_valid high until res_ready
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sub_state_t state_q, state_d;

    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic fa_s, fa_co;
    logic accept;

    assign accept = start_valid && (state_q == IDLE);

    serial_fa_cell u_fa (
        .a  (a_sr_q[0]),
        .b  (~b_sr_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_valid) state_d = RUN;
            RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            IDLE:    start_ready = 1'b1;
            RUN:     busy        = 1'b1;
            DONE:    res_valid   = 1'b1;
            default: start_ready = 1'b0;
        endcase
    end

    always_comb begin
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        if (accept) begin
            a_sr_d   = a;
            b_sr_d   = b;
            res_sr_d = '0;
            carry_d  = 1'b1;
            cnt_d    = '0;
            borrow_d = 1'b0;
            ovf_d    = 1'b0;
        end else if (state_q == RUN) begin
            res_sr_d = {fa_s, res_sr_q[WIDTH-1:1]};
            a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
            carry_d  = fa_co;
            cnt_d    = cnt_q + 1'b1;
            // On the MSB cycle carry_q is the carry into the MSB.
            if (cnt_q == CNT_LAST) begin
                borrow_d = ~fa_co;
                ovf_d    = carry_q ^ fa_co;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign diff   = res_sr_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         busy;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .diff        (diff),
        .borrow      (borrow),
        .ovf         (ovf),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic ref_sub(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                           output logic [W-1:0] e_diff, output logic e_borrow,
                           output logic e_ovf);
        int ua, ub, sa, sb, sd;
        ua = int'(op_a);
        ub = int'(op_b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        sd = sa - sb;
        e_diff   = W'((ua - ub + 256) % 256);
        e_borrow = (ua < ub);
        e_ovf    = (sd < -128) || (sd > 127);
    endtask

    // Accept one operation, measure latency, check results, apply bp cycles of backpressure.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input int bp, input bit poke);
        logic [W-1:0] e_diff;
        logic         e_borrow, e_ovf;
        int           guard;
        int           lat;
        ref_sub(op_a, op_b, e_diff, e_borrow, e_ovf);
        guard = 0;
        while (!start_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_wait", start_ready, 1);
        a = op_a;
        b = op_b;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            if (poke && !res_valid) begin
                check_eq("ready_in_run", start_ready, 0);
                check_eq("busy_in_run", busy, 1);
                start_valid = $urandom_range(0, 1);
                a = W'($urandom);
                b = W'($urandom);
            end
        end
        start_valid = 1'b0;
        check_eq("latency", lat, W + 1);
        check_eq("diff", diff, e_diff);
        check_eq("borrow", borrow, e_borrow);
        check_eq("ovf", ovf, e_ovf);
        check_eq("busy_done", busy, 0);
        check_eq("ready_done", start_ready, 0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check_eq("bp_valid", res_valid, 1);
            check_eq("bp_diff", diff, e_diff);
            check_eq("bp_flags", {borrow, ovf}, {e_borrow, e_ovf});
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", start_ready, 1);
        check_eq("idle_valid", res_valid, 0);
        check_eq("idle_diff_held", diff, e_diff);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_ready", start_ready, 1);
        check_eq("rst_valid", res_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_outs", {diff, borrow, ovf}, 0);
        rst_n = 1'b1;

        run_op(8'd5, 8'd3, 0, 1'b0);
        run_op(8'd3, 8'd5, 0, 1'b0);
        run_op(8'h80, 8'h01, 0, 1'b0);
        run_op(8'h7F, 8'hFF, 0, 1'b0);
        run_op(8'h12, 8'h34, 5, 1'b0);
        run_op(8'hC3, 8'h3C, 0, 1'b1);

        // Reset in the middle of a run.
        @(negedge clk);
        a = 8'hAA;
        b = 8'h55;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_ready", start_ready, 1);
        check_eq("arst_valid", res_valid, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_outs", {diff, borrow, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h00, 8'h00, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), W'($urandom), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `a - b` for `WIDTH`-bit operands, one bit per clock, LSB first, through a single full-adder cell. It is the inverse-direction companion to the team's combinational full adder, and turns that one-cell datapath into a handshaken sequential unit. A producer hands operands in on a valid/ready port. A consumer takes the difference, borrow and signed-overflow flags on a second valid/ready port.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start_valid`  in  1  producer offers operands `a`, `b`
- `start_ready`  out  1  unit can accept operands (IDLE only)
- `a`  in  WIDTH  minuend, sampled on accept
- `b`  in  WIDTH  subtrahend, sampled on accept
- `res_valid`  out  1  result available (DONE only)
- `res_ready`  in  1  consumer takes result
- `diff`  out  WIDTH  `a - b` mod 2^WIDTH
- `borrow`  out  1  1 when unsigned `a < b`
- `ovf`  out  1  signed overflow of `a - b`
- `busy`  out  1  state is RUN

## Operation
- The subtraction is computed as `a + ~b + 1`. The carry register is preloaded to 1, and the cell's `b` input is the inverted LSB of the `b` shift register.
- States:
  - IDLE: `start_ready` = 1. On accept (`start_valid` and `start_ready`), go to RUN. Load the shift registers with `a` and `b`, set carry to 1, clear the bit counter and clear the result shift register.
  - RUN: each cycle, the full-adder cell takes `a_sr[0]`, `~b_sr[0]` and the carry.
    - Its sum is shifted into the result register at the MSB, shifting right.
    - `a_sr` and `b_sr` shift right.
    - Its carry-out is stored.
    - The counter increments.
    - When the counter reaches `WIDTH-1`, go to DONE on that edge.
  - DONE: `res_valid` = 1. When `res_ready` is high, go to IDLE.
- Flags are registered at the final RUN edge:
  - `borrow` = NOT final carry-out.
  - `ovf` = carry into the MSB XOR carry out of the MSB. The carry into the MSB is the carry register value during the last RUN cycle.
- `diff`, `borrow` and `ovf` stay stable from DONE entry until the next accept. They are cleared to 0 on accept.
- `start_valid` is ignored in RUN and DONE; the producer must hold its request.
- `res_ready` is ignored outside DONE.
- There is no back-to-back overlap: after DONE is left, the next accept can occur no earlier than the following cycle in IDLE.

## Timing
- Reset values: state IDLE, `start_ready` = 1, `res_valid` = 0, `busy` = 0, `diff` = 0, `borrow` = 0, `ovf` = 0. All internal registers are 0.
- `start_ready`, `res_valid` and `busy` are decoded directly from registered state, with no input-to-output combinational path.
- Latency: accept in cycle 0, RUN in cycles 1..WIDTH, `res_valid` high from cycle WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles when `res_ready` is held high.
- Backpressure: `res_ready` low keeps the unit in DONE indefinitely with outputs held.
- Asserting `rst_n` low at any point, including mid-RUN, asynchronously returns everything to reset values. The partial result is discarded. The first accept is possible in the first cycle after `rst_n` is released.
- Width rule: the counter is `$clog2(WIDTH)` bits and never wraps, because it is cleared on accept.

## Structure
- Package `serial_arith_pkg` holds:
  - the state typedef `sub_state_t` {IDLE, RUN, DONE};
  - a function returning the counter width from `WIDTH`.
- Sub-module `serial_fa_cell` is a purely combinational 1-bit full adder with ports `a`, `b`, `ci` → `s`, `co`. It is instantiated once.
- The top level holds the FSM, the three shift registers, the carry register, the counter and the flag registers.

## Test plan
All scenarios use WIDTH = 8.
- Basic: `a` = 5, `b` = 3 → `diff` = 0x02, `borrow` = 0, `ovf` = 0. `res_valid` rises exactly 9 cycles after the accept cycle.
- Negative result: `a` = 3, `b` = 5 → `diff` = 0xFE, `borrow` = 1, `ovf` = 0.
- Signed overflow: `a` = 0x80, `b` = 0x01 → `diff` = 0x7F, `borrow` = 0, `ovf` = 1. Also `a` = 0x7F, `b` = 0xFF → `diff` = 0x80, `borrow` = 1, `ovf` = 1.
- Backpressure and ignore:
  - Hold `res_ready` low for 5 cycles in DONE → outputs unchanged and `res_valid` held high.
  - Toggle `start_valid` with new operands during RUN → result still from the original operands, and `start_ready` stays 0 until IDLE.
- Reset mid-RUN: pulse `rst_n` low in cycle 4 of `a` = 0xAA, `b` = 0x55 → all outputs are immediately at reset values. A new accept of `a` = 0, `b` = 0 then gives `diff` = 0, `borrow` = 0, `ovf` = 0.
